// File: rtl/memwb_stage.sv
// ----------------------------------------------------------------------------
// memwb_stage
//
// MEM/WB pipeline stage with a valid/ready handshake and a two-entry skid
// buffer (main + skid). It also contains the write-back mux and generates the
// register-file write enable. When downstream is ready it passes one transfer
// per cycle with one cycle of latency and no bubbles.
//
// Parameters
//   DW    data width of ALU result, memory read data and wb_data
//   AW    register address width
//   WB_W  WB control width (>= 2): bit0 RegWrite, bit1 MemToReg, rest passed on
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   flush           kill all held entries; beats accept and consume
//   in_valid/ready  upstream handshake (MEM stage)
//   wb_ctrl_in, dmem_rdata_in, alu_result_in, dest_addr_in   upstream payload
//   out_valid/ready downstream handshake (WB / register file)
//   wb_ctrl, dmem_rdata, alu_result, dest_addr               registered payload
//   wb_data         MemToReg ? dmem_rdata : alu_result
//   wb_we           out_valid & out_ready & RegWrite & (dest_addr != 0)
//
// Optional feature (macro MEMWB_FWD_EN)
//   Adds rs_addr/rt_addr inputs and fwd_rs/fwd_rt/fwd_data outputs. These
//   compare the held entry against the source registers, combinationally.
//   When the macro is undefined the ports and the compare logic are absent.
// ----------------------------------------------------------------------------
module memwb_stage #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned WB_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WB_W-1:0] wb_ctrl_in,
    input  logic [DW-1:0]   dmem_rdata_in,
    input  logic [DW-1:0]   alu_result_in,
    input  logic [AW-1:0]   dest_addr_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WB_W-1:0] wb_ctrl,
    output logic [DW-1:0]   dmem_rdata,
    output logic [DW-1:0]   alu_result,
    output logic [AW-1:0]   dest_addr,
    output logic [DW-1:0]   wb_data,
    output logic            wb_we
`ifdef MEMWB_FWD_EN
    ,
    input  logic [AW-1:0]   rs_addr,
    input  logic [AW-1:0]   rt_addr,
    output logic            fwd_rs,
    output logic            fwd_rt,
    output logic [DW-1:0]   fwd_data
`endif
);

    typedef struct packed {
        logic [WB_W-1:0] ctrl;
        logic [DW-1:0]   dmem;
        logic [DW-1:0]   alu;
        logic [AW-1:0]   dest;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   m_v_q, m_v_d;
    logic   s_v_q, s_v_d;

    entry_t in_entry;
    logic   accept;
    logic   consume;
    logic   dest_nz;

    assign in_entry = '{ctrl: wb_ctrl_in, dmem: dmem_rdata_in,
                        alu: alu_result_in, dest: dest_addr_in};

    // The skid entry is the only reason to stall upstream. Reset also holds
    // in_ready low so that nothing is accepted while state is being cleared.
    assign in_ready = ~s_v_q & ~reset;
    assign accept   = in_valid & in_ready;
    assign consume  = m_v_q & out_ready;

    always_comb begin
        m_v_d  = m_v_q;
        s_v_d  = s_v_q;
        main_d = main_q;
        skid_d = skid_q;

        if (flush) begin
            // Data regs keep their contents; only the flags matter.
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (!m_v_q || consume) begin
            // Main is free this cycle. The skid entry is older than any input,
            // so it goes first. accept cannot occur while s_v_q is set.
            if (s_v_q) begin
                main_d = skid_q;
                m_v_d  = 1'b1;
                s_v_d  = 1'b0;
            end else if (accept) begin
                main_d = in_entry;
                m_v_d  = 1'b1;
            end else begin
                m_v_d = 1'b0;
            end
        end else if (accept) begin
            // Main is stalled: park the word just accepted in the skid slot.
            skid_d = in_entry;
            s_v_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_v_q  <= 1'b0;
            s_v_q  <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            m_v_q  <= m_v_d;
            s_v_q  <= s_v_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign out_valid  = m_v_q;
    assign wb_ctrl    = main_q.ctrl;
    assign dmem_rdata = main_q.dmem;
    assign alu_result = main_q.alu;
    assign dest_addr  = main_q.dest;

    // R0 is hardwired, so a write to it is suppressed but the data still flows.
    assign dest_nz = (main_q.dest != '0);
    assign wb_data = main_q.ctrl[1] ? main_q.dmem : main_q.alu;
    assign wb_we   = consume & main_q.ctrl[0] & dest_nz;

`ifdef MEMWB_FWD_EN
    logic fwd_cand;

    // Only a valid RegWrite entry to a non-zero register may forward.
    assign fwd_cand = m_v_q & main_q.ctrl[0] & dest_nz;
    assign fwd_rs   = fwd_cand & (main_q.dest == rs_addr);
    assign fwd_rt   = fwd_cand & (main_q.dest == rt_addr);
    assign fwd_data = wb_data;
`endif

    // A stalled entry must not change under the consumer.
    stall_stable_a : assert property (@(posedge clk) disable iff (reset)
        (m_v_q && !out_ready && !flush) |=> (m_v_q && $stable(main_q)));

    // The skid slot is only ever filled behind an occupied main slot.
    skid_order_a : assert property (@(posedge clk) disable iff (reset)
        s_v_q |-> m_v_q);

endmodule

// File: tb/tb_memwb_stage.sv
module tb_memwb_stage;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned WB_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [WB_W-1:0] wb_ctrl_in;
    logic [DW-1:0]   dmem_rdata_in;
    logic [DW-1:0]   alu_result_in;
    logic [AW-1:0]   dest_addr_in;
    logic            out_valid;
    logic            out_ready;
    logic [WB_W-1:0] wb_ctrl;
    logic [DW-1:0]   dmem_rdata;
    logic [DW-1:0]   alu_result;
    logic [AW-1:0]   dest_addr;
    logic [DW-1:0]   wb_data;
    logic            wb_we;
`ifdef MEMWB_FWD_EN
    logic [AW-1:0]   rs_addr;
    logic [AW-1:0]   rt_addr;
    logic            fwd_rs;
    logic            fwd_rt;
    logic [DW-1:0]   fwd_data;
`endif

    memwb_stage #(
        .DW   (DW),
        .AW   (AW),
        .WB_W (WB_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .wb_ctrl_in    (wb_ctrl_in),
        .dmem_rdata_in (dmem_rdata_in),
        .alu_result_in (alu_result_in),
        .dest_addr_in  (dest_addr_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .wb_ctrl       (wb_ctrl),
        .dmem_rdata    (dmem_rdata),
        .alu_result    (alu_result),
        .dest_addr     (dest_addr),
        .wb_data       (wb_data),
        .wb_we         (wb_we)
`ifdef MEMWB_FWD_EN
        ,
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .fwd_rs        (fwd_rs),
        .fwd_rt        (fwd_rt),
        .fwd_data      (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WB_W-1:0] ctrl;
        logic [DW-1:0]   dmem;
        logic [DW-1:0]   alu;
        logic [AW-1:0]   dest;
        int              cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_acc   = 0;
    bit   lat_chk = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [WB_W-1:0] c, input logic [DW-1:0] m,
                         input logic [DW-1:0] a, input logic [AW-1:0] d);
        in_valid      = v;
        wb_ctrl_in    = c;
        dmem_rdata_in = m;
        alu_result_in = a;
        dest_addr_in  = d;
    endtask

    // Called at a falling edge with inputs already driven: settles, scores the
    // handshakes of this cycle, then advances to the next falling edge.
    task automatic tick();
        exp_t e;
        logic acc;
        logic cons;
        logic [DW-1:0] wd;
        #1;
        if (reset) begin
            q.delete();
        end else begin
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cons) begin
                if (q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    e  = q.pop_front();
                    wd = e.ctrl[1] ? e.dmem : e.alu;
                    check("ctrl", 64'(wb_ctrl), 64'(e.ctrl));
                    check("dmem", 64'(dmem_rdata), 64'(e.dmem));
                    check("alu", 64'(alu_result), 64'(e.alu));
                    check("dest", 64'(dest_addr), 64'(e.dest));
                    check("wb_data", 64'(wb_data), 64'(wd));
                    check("wb_we", 64'(wb_we), 64'(e.ctrl[0] && (e.dest != 0)));
                    if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'(1));
                end
            end else begin
                check("wb_we_idle", 64'(wb_we), 64'(0));
            end
            if (flush) begin
                q.delete();
            end else if (acc) begin
                n_acc++;
                q.push_back('{ctrl: wb_ctrl_in, dmem: dmem_rdata_in, alu: alu_result_in,
                              dest: dest_addr_in, cyc: cyc});
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input string tag);
        drive(1'b0, '0, '0, '0, '0);
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < 8 && q.size() != 0; i++) tick();
        check(tag, 64'(q.size()), 64'(0));
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
`ifdef MEMWB_FWD_EN
        rs_addr = '0;
        rt_addr = '0;
`endif
        // 1: reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_in_ready", 64'(in_ready), 64'(0));
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_regs", {dest_addr, wb_ctrl, alu_result[15:0]}, 64'(0));
            check("rst_dmem", 64'(dmem_rdata), 64'(0));
            check("rst_wb", {wb_we, wb_data}, 64'(0));
        end
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        cyc++;

        // 2: streaming, one word per cycle
        out_ready = 1'b1;
        lat_chk   = 1;
        n_acc     = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'b01, $urandom, 32'h1000 + 32'(i), AW'(5 + i));
            tick();
        end
        drive(1'b0, '0, '0, '0, '0);
        tick();
        lat_chk = 0;
        check("stream_accepts", 64'(n_acc), 64'(8));
        check("stream_drained", 64'(q.size()), 64'(0));

        // 3: back-pressure fills main then skid
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'h0, 32'hA0, 5'd1);
        tick();
        drive(1'b1, 2'b01, 32'h0, 32'hB0, 5'd2);
        tick();
        drive(1'b1, 2'b01, 32'h0, 32'hC0, 5'd3);
        #1;
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        check("bp_head", 64'(alu_result), 64'(32'hA0));
        tick();
        tick();
        check("bp_stored", 64'(q.size()), 64'(2));
        drain("bp_drained");

        // 4: load to R0: data passes, no write
        drive(1'b1, 2'b11, 32'hDEADBEEF, 32'h100, 5'd0);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        #1;
        check("ld_r0_wb_data", 64'(wb_data), 64'(32'hDEADBEEF));
        check("ld_r0_wb_we", 64'(wb_we), 64'(0));
        tick();

        // 5: flush with both slots full and an input offered
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'h0, 32'h11, 5'd7);
        tick();
        drive(1'b1, 2'b01, 32'h0, 32'h22, 5'd8);
        tick();
`ifdef MEMWB_FWD_EN
        // 6: forwarding from the held entry (dest 7)
        rs_addr = 5'd7;
        rt_addr = 5'd3;
        #1;
        check("fwd_rs", 64'(fwd_rs), 64'(1));
        check("fwd_rt", 64'(fwd_rt), 64'(0));
        check("fwd_data", 64'(fwd_data), 64'(32'h11));
`endif
        flush = 1'b1;
        drive(1'b1, 2'b01, 32'h0, 32'h33, 5'd9);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        out_ready = 1'b1;
        #1;
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_in_ready", 64'(in_ready), 64'(1));
`ifdef MEMWB_FWD_EN
        check("flush_fwd", {fwd_rs, fwd_rt}, 64'(0));
`endif
        for (int i = 0; i < 3; i++) tick();

        // Flush while only main is full: the word accepted that cycle is lost.
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'h0, 32'h44, 5'd4);
        tick();
        flush = 1'b1;
        drive(1'b1, 2'b01, 32'h0, 32'h55, 5'd5);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        #1;
        check("flush_acc_dropped", 64'(out_valid), 64'(0));
        drain("flush_drained");

        // Reset mid-transfer drops everything.
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'h0, 32'h66, 5'd6);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        tick();

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, $urandom,
                  AW'($urandom_range(0, 7)));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = 1'($urandom_range(0, 31) == 0);
            tick();
        end
        drain("rand_drained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
